// File: rtl/mixer_polifonico_pkg.sv
// Shared types and width helpers for the polyphonic mixer.
// Holds the FSM state type, accumulator/gain width rules and output saturation.
package mixer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACUM,
        FIM
    } estado_t;

    function automatic int larg_ganho(input int w_ganho);
        return w_ganho + 1;
    endfunction

    // Wide enough for N full-scale samples times full-scale gain.
    function automatic int larg_acum(input int w_amostra, input int w_ganho, input int n_vozes);
        return w_amostra + w_ganho + 1 + $clog2(n_vozes);
    endfunction

    function automatic logic [63:0] satura(input logic [63:0] valor, input int largura);
        logic [63:0] maximo;
        maximo = (64'd1 << largura) - 64'd1;
        return (valor > maximo) ? maximo : valor;
    endfunction

endpackage

// File: rtl/mixer_polifonico_if.sv
// Sample/key inputs and mixed-output bus between the voice bank, the mixer and the DAC.
interface mixer_polifonico_if #(
    parameter int N_VOZES   = 10,
    parameter int W_AMOSTRA = 8,
    parameter int W_SAIDA   = 8
);
    logic                           tick;
    logic [N_VOZES-1:0]             teclas;
    logic [N_VOZES*W_AMOSTRA-1:0]   amostras;
    logic [W_SAIDA-1:0]             saida;
    logic                           valido;
    logic                           ocupado;
    logic                           perdido;

    modport master (
        output tick, teclas, amostras,
        input  saida, valido, ocupado, perdido
    );

    modport slave (
        input  tick, teclas, amostras,
        output saida, valido, ocupado, perdido
    );
endinterface

// File: rtl/mixer_polifonico_envelope_voz.sv
// Per-voice attack/release gain register, stepped once per enabled update.
// Only present when MIXER_ENVELOPE_EN is defined.
`ifdef MIXER_ENVELOPE_EN
module envelope_voz
    import mixer_pkg::*;
#(
    parameter int W_GANHO = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          passo,
    input  logic                          tecla,
    output logic [larg_ganho(W_GANHO)-1:0] ganho
);
    localparam int W_G = larg_ganho(W_GANHO);
    localparam logic [W_G-1:0] CHEIO = {1'b1, {W_GANHO{1'b0}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ganho <= '0;
        end else if (passo) begin
            if (tecla && (ganho < CHEIO)) begin
                ganho <= ganho + 1'b1;
            end else if (!tecla && (ganho != '0)) begin
                ganho <= ganho - 1'b1;
            end
        end
    end
endmodule
`endif

// File: rtl/mixer_polifonico.sv
// Time-multiplexed N-voice mixer: one voice per clock, scaled, saturated, strobed out.
// Define MIXER_ENVELOPE_EN for ramped attack/release gains; otherwise keys gate instantly.
module mixer_polifonico
    import mixer_pkg::*;
#(
    parameter int N_VOZES   = 10,
    parameter int W_AMOSTRA = 8,
    parameter int W_SAIDA   = 8,
    parameter int W_GANHO   = 4,
    parameter int SHIFT_MIX = 2,
    parameter int DIV_ENV   = 64
) (
    input logic               clk,
    input logic               rst,
    mixer_polifonico_if.slave bus
);
    localparam int W_G    = larg_ganho(W_GANHO);
    localparam int W_ACC  = larg_acum(W_AMOSTRA, W_GANHO, N_VOZES);
    localparam int W_PROD = W_AMOSTRA + W_G;
    localparam int W_IDX  = (N_VOZES > 1) ? $clog2(N_VOZES) : 1;
    localparam int DESLOC = W_GANHO + SHIFT_MIX;

    estado_t              estado;
    logic [W_IDX-1:0]     idx;
    logic [W_ACC-1:0]     acc;
    logic [W_AMOSTRA-1:0] snap_amostra [N_VOZES];
    logic [N_VOZES-1:0]   snap_tecla;
    logic [W_G-1:0]       ganho [N_VOZES];
    logic [W_AMOSTRA-1:0] amostra_sel;
    logic [W_G-1:0]       ganho_sel;
    logic [W_PROD-1:0]    produto;
    logic [W_ACC-1:0]     mix;
    logic [63:0]          saturado;
    logic                 fim_voz;

    assign amostra_sel = snap_amostra[idx];
    assign ganho_sel   = ganho[idx];
    assign produto     = W_PROD'(amostra_sel) * W_PROD'(ganho_sel);
    assign mix         = acc >> DESLOC;
    assign saturado    = satura(64'(mix), W_SAIDA);
    assign fim_voz     = (idx == W_IDX'(N_VOZES - 1));

`ifdef MIXER_ENVELOPE_EN
    localparam int W_DIV = (DIV_ENV > 1) ? $clog2(DIV_ENV) : 1;

    logic [W_DIV-1:0]   divisor;
    logic               atualiza;
    logic [N_VOZES-1:0] passo;

    // Each envelope steps in its own ACUM slot, after its product has used the old gain.
    for (genvar i = 0; i < N_VOZES; i++) begin : g_voz
        assign passo[i] = atualiza && (estado == ACUM) && (idx == W_IDX'(i));

        envelope_voz #(
            .W_GANHO (W_GANHO)
        ) u_envelope (
            .clk   (clk),
            .rst   (rst),
            .passo (passo[i]),
            .tecla (snap_tecla[i]),
            .ganho (ganho[i])
        );
    end
`else
    localparam logic [W_G-1:0] CHEIO = {1'b1, {W_GANHO{1'b0}}};

    for (genvar i = 0; i < N_VOZES; i++) begin : g_voz
        assign ganho[i] = snap_tecla[i] ? CHEIO : '0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado      <= IDLE;
            idx         <= '0;
            acc         <= '0;
            snap_tecla  <= '0;
            for (int i = 0; i < N_VOZES; i++) begin
                snap_amostra[i] <= '0;
            end
            bus.saida   <= '0;
            bus.valido  <= 1'b0;
            bus.ocupado <= 1'b0;
            bus.perdido <= 1'b0;
`ifdef MIXER_ENVELOPE_EN
            divisor     <= '0;
            atualiza    <= 1'b0;
`endif
        end else begin
            bus.valido <= 1'b0;
            if (bus.tick && (estado != IDLE)) begin
                bus.perdido <= 1'b1;
            end

            case (estado)
                IDLE: begin
                    if (bus.tick) begin
                        for (int i = 0; i < N_VOZES; i++) begin
                            snap_amostra[i] <= bus.amostras[i*W_AMOSTRA +: W_AMOSTRA];
                        end
                        snap_tecla  <= bus.teclas;
                        acc         <= '0;
                        idx         <= '0;
                        bus.ocupado <= 1'b1;
                        estado      <= ACUM;
`ifdef MIXER_ENVELOPE_EN
                        // Only the tick that wraps the divider back to 0 steps the envelopes.
                        if (divisor == W_DIV'(DIV_ENV - 1)) begin
                            divisor  <= '0;
                            atualiza <= 1'b1;
                        end else begin
                            divisor  <= divisor + 1'b1;
                            atualiza <= 1'b0;
                        end
`endif
                    end
                end
                ACUM: begin
                    acc <= acc + W_ACC'(produto);
                    if (fim_voz) begin
                        estado <= FIM;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                FIM: begin
                    bus.saida   <= saturado[W_SAIDA-1:0];
                    bus.valido  <= 1'b1;
                    bus.ocupado <= 1'b0;
                    estado      <= IDLE;
                end
                default: begin
                    estado <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mixer_polifonico.sv
// Self-checking bench for mixer_polifonico: table vectors, envelope ramps, dropped ticks,
// mid-mix reset and randomized mixes against a plain-arithmetic reference model.
module tb_mixer_polifonico;
    localparam int N     = 10;
    localparam int WA    = 8;
    localparam int WS    = 8;
    localparam int SHIFT = 2;
`ifdef MIXER_ENVELOPE_EN
    localparam int WG    = 2;
    localparam int DIV   = 1;
`else
    localparam int WG    = 4;
    localparam int DIV   = 64;
`endif
    localparam int LATENCIA = N + 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mixer_polifonico_if #(.N_VOZES(N), .W_AMOSTRA(WA), .W_SAIDA(WS)) bus ();

    mixer_polifonico #(
        .N_VOZES   (N),
        .W_AMOSTRA (WA),
        .W_SAIDA   (WS),
        .W_GANHO   (WG),
        .SHIFT_MIX (SHIFT),
        .DIV_ENV   (DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [N-1:0] teclas;
        int           amostraOn;
        int           amostraOff;
        int           esperado;
        string        nome;
    } vetor_t;

    int testsRun    = 0;
    int testsFailed = 0;
    int modeloGanho [N];
    int modeloAceites;
    int ultimoEsperado;

    task automatic checkOutput(input string nome, input int actual, input int esperado);
        testsRun++;
        if (actual !== esperado) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", nome, actual, esperado);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < N; i++) modeloGanho[i] = 0;
        modeloAceites = 0;
    endtask

    // Reference: weighted sum with pre-update gains, then shift and clamp.
    task automatic modelMix(input logic [N-1:0] teclas, input logic [N*WA-1:0] amostras,
                            output int esperado);
        longint soma;
        int     g;
        int     a;
        bit     passo;
        soma = 0;
        modeloAceites++;
        passo = ((modeloAceites % DIV) == 0);
        for (int i = 0; i < N; i++) begin
            a = int'(amostras[i*WA +: WA]);
`ifdef MIXER_ENVELOPE_EN
            g = modeloGanho[i];
            if (passo) begin
                if (teclas[i] && g < (1 << WG)) modeloGanho[i] = g + 1;
                else if (!teclas[i] && g > 0)   modeloGanho[i] = g - 1;
            end
`else
            g = teclas[i] ? (1 << WG) : 0;
`endif
            soma += longint'(a) * longint'(g);
        end
        soma = soma >> (WG + SHIFT);
        esperado = (soma > ((1 << WS) - 1)) ? ((1 << WS) - 1) : int'(soma);
    endtask

    function automatic logic [N*WA-1:0] pack(input logic [N-1:0] teclas, input int on, input int off);
        logic [N*WA-1:0] r;
        for (int i = 0; i < N; i++) r[i*WA +: WA] = teclas[i] ? WA'(on) : WA'(off);
        return r;
    endfunction

    task automatic applyStimulus(input logic [N-1:0] teclas, input logic [N*WA-1:0] amostras);
        @(negedge clk);
        bus.tick     = 1'b1;
        bus.teclas   = teclas;
        bus.amostras = amostras;
        @(negedge clk);
        bus.tick     = 1'b0;
    endtask

    task automatic waitValido(output int ciclos, output int ocupadoCiclos, output bit ok);
        ciclos        = 0;
        ocupadoCiclos = bus.ocupado ? 1 : 0;
        ok            = 1'b0;
        while (ciclos < 40 && !ok) begin
            @(negedge clk);
            ciclos++;
            if (bus.ocupado) ocupadoCiclos++;
            if (bus.valido) ok = 1'b1;
        end
    endtask

    task automatic runMix(input string nome, input logic [N-1:0] teclas,
                          input logic [N*WA-1:0] amostras, input int tabela, input bit timing);
        int modelo, esp, ciclos, occ;
        bit ok;
        modelMix(teclas, amostras, modelo);
        esp = (tabela >= 0) ? tabela : modelo;
        applyStimulus(teclas, amostras);
        waitValido(ciclos, occ, ok);
        checkOutput({nome, " valido seen"}, int'(ok), 1);
        if (ok) checkOutput({nome, " saida"}, int'(bus.saida), esp);
        if (timing) begin
            checkOutput({nome, " latency"}, ciclos, LATENCIA);
            checkOutput({nome, " ocupado cycles"}, occ, LATENCIA);
        end
        @(negedge clk);
        checkOutput({nome, " valido one cycle"}, int'(bus.valido), 0);
        ultimoEsperado = esp;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int esp, ciclos, occ;
        bit ok;
        logic [N*WA-1:0] amostras;
        logic [N-1:0]    teclas;
`ifndef MIXER_ENVELOPE_EN
        vetor_t tabela [9];
        tabela[0] = '{10'h3FF, 40,  0,   100, "all keys 40"};
        tabela[1] = '{10'h3FF, 255, 255, 255, "all keys 255 saturate"};
        tabela[2] = '{10'h003, 200, 255, 100, "two keys 200"};
        tabela[3] = '{10'h000, 255, 255, 0,   "no keys"};
        tabela[4] = '{10'h200, 255, 0,   63,  "key9 only"};
        tabela[5] = '{10'h2AA, 100, 0,   125, "odd keys 100"};
        tabela[6] = '{10'h3FF, 102, 0,   255, "exact full scale"};
        tabela[7] = '{10'h3FF, 103, 0,   255, "just over full scale"};
        tabela[8] = '{10'h3FF, 101, 0,   252, "just under full scale"};
`else
        int ataque  [6] = '{0, 8, 16, 24, 32, 32};
        int soltura [6] = '{32, 24, 16, 8, 0, 0};
`endif

        rst          = 1'b1;
        bus.tick     = 1'b0;
        bus.teclas   = '0;
        bus.amostras = '0;
        modelReset();
        #2;
        checkOutput("reset saida", int'(bus.saida), 0);
        checkOutput("reset valido", int'(bus.valido), 0);
        checkOutput("reset ocupado", int'(bus.ocupado), 0);
        checkOutput("reset perdido", int'(bus.perdido), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

`ifndef MIXER_ENVELOPE_EN
        foreach (tabela[k]) begin
            runMix(tabela[k].nome, tabela[k].teclas,
                   pack(tabela[k].teclas, tabela[k].amostraOn, tabela[k].amostraOff),
                   tabela[k].esperado, k == 0);
        end
`else
        for (int k = 0; k < 6; k++) begin
            runMix($sformatf("attack step %0d", k), 10'h001, pack(10'h001, 128, 0), ataque[k], k == 0);
        end
        for (int k = 0; k < 6; k++) begin
            runMix($sformatf("release step %0d", k), 10'h000, pack(10'h001, 128, 0), soltura[k], 1'b0);
        end
`endif
        repeat (5) @(negedge clk);
        checkOutput("saida holds", int'(bus.saida), ultimoEsperado);

        for (int k = 0; k < 20; k++) begin
            teclas = N'($urandom);
            for (int i = 0; i < N; i++) amostras[i*WA +: WA] = WA'($urandom_range(0, 255));
            runMix($sformatf("random %0d", k), teclas, amostras, -1, 1'b1);
        end

        // Second tick three cycles into a mix: dropped, and the snapshot is kept.
        teclas   = '1;
        amostras = pack(teclas, 50, 50);
        modelMix(teclas, amostras, esp);
        @(negedge clk);
        bus.tick = 1'b1; bus.teclas = teclas; bus.amostras = amostras;
        @(negedge clk);
        bus.tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.tick = 1'b1; bus.teclas = '0; bus.amostras = '0;
        @(negedge clk);
        bus.tick = 1'b0;
        checkOutput("perdido after dropped tick", int'(bus.perdido), 1);
        waitValido(ciclos, occ, ok);
        checkOutput("dropped tick valido seen", int'(ok), 1);
        if (ok) checkOutput("dropped tick saida", int'(bus.saida), esp);
        @(negedge clk);
        checkOutput("dropped tick not queued", int'(bus.ocupado), 0);
        checkOutput("perdido sticky", int'(bus.perdido), 1);

        // Asynchronous reset in the middle of ACUM.
        applyStimulus('1, pack('1, 77, 77));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midmix reset saida", int'(bus.saida), 0);
        checkOutput("midmix reset valido", int'(bus.valido), 0);
        checkOutput("midmix reset ocupado", int'(bus.ocupado), 0);
        checkOutput("midmix reset perdido", int'(bus.perdido), 0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        runMix("after midmix reset", 10'h0F3, pack(10'h0F3, 60, 9), -1, 1'b1);
        runMix("second after reset", 10'h3FF, pack(10'h3FF, 30, 30), -1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/mixer_polifonico.md
# mixer_polifonico

Parametrised polyphonic voice mixer that sits between the per-key `instrumento` voice bank and `dac1bit`. It replaces the single-voice tap with a time-multiplexed sum of all N voice samples. Each voice is weighted by a per-voice gain, optionally ramped as an attack/release envelope. The sum is scaled for headroom, saturated, and registered with a valid strobe, so all pressed keys reach the DAC at once.

## Interface
Parameters:
- `N_VOZES`, 10, number of voice channels (≥2)
- `W_AMOSTRA`, 8, unsigned voice sample width
- `W_SAIDA`, 8, unsigned mixed output width
- `W_GANHO`, 4, envelope resolution; gain ranges 0..2^W_GANHO (full scale = 2^W_GANHO)
- `SHIFT_MIX`, 2, headroom right-shift applied after gain normalisation
- `DIV_ENV`, 64, accepted ticks per envelope step (≥1)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `tick`  in  1  sample strobe, one cycle wide
- `teclas`  in  N_VOZES  key-on per voice, 1 = pressed
- `amostras`  in  N_VOZES*W_AMOSTRA  packed samples, voice i at bits [i*W_AMOSTRA +: W_AMOSTRA]
- `saida`  out  W_SAIDA  mixed sample to DAC
- `valido`  out  1  one-cycle pulse when `saida` updates
- `ocupado`  out  1  high while a mix is in progress
- `perdido`  out  1  sticky flag: a tick was dropped

## Operation
- States: IDLE, ACUM, FIM.
- IDLE + `tick` at a clock edge:
  - snapshot `amostras` and `teclas`
  - clear the accumulator
  - set index to 0
  - go to ACUM
- ACUM, one voice per cycle: accumulator += sample[idx] × ganho[idx]. Same cycle, the gain of voice idx gets its envelope update. After idx = N_VOZES-1, go to FIM.
- FIM:
  - mix = acc >> (W_GANHO + SHIFT_MIX)
  - if mix > 2^W_SAIDA-1, `saida` = all ones; else `saida` = mix[W_SAIDA-1:0]
  - `valido` = 1
  - go to IDLE
- Accumulator width is W_AMOSTRA + W_GANHO + 1 + clog2(N_VOZES); it cannot overflow.
- Gain registers are W_GANHO+1 bits wide, unsigned.
- Envelope step: a tick divider counts accepted ticks 0..DIV_ENV-1. Envelope updates happen only in the mix whose accepted tick wrapped the divider to 0. On an update:
  - key set and ganho < 2^W_GANHO: ganho+1 (attack)
  - key clear and ganho > 0: ganho-1 (release)
  - otherwise: hold
- Products always use the gain value from before that cycle's update.
- `tick` at an edge where state ≠ IDLE: the tick is ignored, `perdido` is set, and the mix in progress is unaffected. `perdido` clears only on reset.
- `ocupado` = (state ≠ IDLE).
- Reset, at any time including mid-ACUM: `saida`=0, `valido`=0, `ocupado`=0, `perdido`=0, all gains 0, accumulator 0, divider 0, state IDLE.

## Timing
- Tick accepted at edge e0.
- Edges e1..eN accumulate voices 0..N-1 (N = N_VOZES).
- Edge eN+1 loads `saida` and raises `valido`. `valido` is high for exactly one cycle, between eN+1 and eN+2.
- Latency from tick to `valido` is N+1 clocks.
- Minimum accepted tick spacing is N+2 clocks; the earliest next accept is at eN+2.
- `saida` holds its value between updates.
- `ocupado` rises after e0 and falls after eN+1.
- Samples and keys are sampled only at e0; changes during ACUM have no effect.

## Configuration
- `MIXER_ENVELOPE_EN` defined: attack/release envelope and tick divider as described above.
- Undefined:
  - no divider, no gain registers
  - gain for voice i = 2^W_GANHO if the snapshot key i is set, else 0 (instant gating)
  - all other behaviour and timing identical

## Structure
- Package `mixer_pkg`:
  - state enum (IDLE, ACUM, FIM)
  - accumulator-width and gain-width localparam functions
  - saturation function
- Sub-module `envelope_voz`, instantiated N_VOZES times:
  - holds one gain register
  - inputs: `clk`, `rst`, `passo` (update enable), `tecla`
  - output: `ganho`
- The mixer pulses `passo` for voice idx in its ACUM cycle. `envelope_voz` is compiled only under `MIXER_ENVELOPE_EN`.

## Test plan
All scenarios use defaults unless stated.
- Reset: assert `rst` asynchronously between edges. All outputs are 0 immediately. The first tick after release produces `valido` exactly 11 clocks later.
- No macro, all keys on, all samples 40: sum is 400, 400>>2 = 100. `saida`=100, and `ocupado` is high for 11 cycles.
- No macro, all keys on, all samples 255: 2550>>2 = 637, so `saida` saturates to 255.
- No macro, `teclas`=0b0000000011, samples 200 (others 255): `saida`=100.
- Macro on, W_GANHO=2, DIV_ENV=1, key 0 on, sample 128, others off: successive `saida` values are 0, 8, 16, 24, 32, 32. After key 0 releases: 32, 24, 16, 8, 0, 0.
- Tick re-asserted 3 cycles after an accepted tick: it is ignored and `perdido`=1, while the first mix result is correct. Then assert `rst` mid-ACUM: all state clears, and the next tick mixes correctly.
